seq_ripple_adder: RTL and testbench

SEQ_RIPPLE_ADDER -- requirements
Module: seq_ripple_adder

---
 rtl/seq_ripple_adder.sv | 115 +++++++++++
 tb/tb_seq_ripple_adder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_ripple_adder.sv
// Multi-cycle ripple adder: adds CHUNK bits per cycle with an IDLE/BUSY/DONE handshake FSM.
// Optional macro SEQ_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module seq_ripple_adder #(
  parameter int WIDTH = 28,
  parameter int CHUNK = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SEQ_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] cs;
  logic             cco;

  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  always_comb begin
    ca        = opa[int'(cnt)*CHUNK +: CHUNK];
    cb        = opb[int'(cnt)*CHUNK +: CHUNK];
    {cco, cs} = add_chunk(ca, cb, carry);
  end

`ifdef SEQ_ADDER_OVF_EN
  // Carry into the MSB is recovered from the MSB's own sum bit on the last chunk.
  logic cmsb;
  always_comb cmsb = ca[CHUNK-1] ^ cb[CHUNK-1] ^ cs[CHUNK-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
`ifdef SEQ_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa      <= a;
            opb      <= b;
            carry    <= cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          sum[int'(cnt)*CHUNK +: CHUNK] <= cs;
          carry <= cco;
          if (cnt == LAST) begin
            cnt       <= '0;
            cout      <= cco;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef SEQ_ADDER_OVF_EN
            ovf       <= cmsb ^ cco;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // Consumption returns to IDLE only; a new accept needs the following cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_ripple_adder.sv
// Directed and random-vector bench for seq_ripple_adder (WIDTH=28, CHUNK=7).
module tb_seq_ripple_adder;
  localparam int W = 28;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         out_valid;
  logic         out_ready = 1'b0;
`ifdef SEQ_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int failures = 0;

  seq_ripple_adder #(.WIDTH(W), .CHUNK(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef SEQ_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand set, waits (bounded) for out_valid, leaves result held.
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci);
    int n;
    a = x; b = y; cin = ci; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, out_valid, 1'b1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [W:0] expq[$];
  logic [W:0] exp_r;
  int  cyc, last_acc, n_acc, n_res;
  bit  will_acc, seen;

  initial begin
    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, '0);
    chk("rst_cout", cout, 1'b0);

    // All-ones wrap, exact latency of 4
    a = 28'hFFFFFFF; b = 28'h0000001; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t030_in_ready_busy", in_ready, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t030_lat%0d", i), out_valid, (i == 4));
    end
    chk("t030_sum", sum, 28'h0000000);
    chk("t030_cout", cout, 1'b1);
    consume();
    chk("t030_ov_clear", out_valid, 1'b0);
    chk("t030_in_ready", in_ready, 1'b1);

    // Backpressure hold, input noise ignored
    a = 28'h1234567; b = 28'h0ABCDEF; cin = 1'b1; in_valid = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      in_valid = i[0];
      a = W'($urandom); b = W'($urandom); cin = ~cin;
      tick();
      chk("t031_busy_in_ready", in_ready, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      chk("t031_ov", out_valid, 1'b1);
      chk("t031_sum", sum, 28'h1CF1357);
      chk("t031_cout", cout, 1'b0);
      chk("t031_in_ready", in_ready, 1'b0);
      in_valid = ~in_valid;
      a = W'($urandom); b = W'($urandom);
      tick();
    end
    in_valid = 1'b0;
    consume();
    chk("t031_ov_clear", out_valid, 1'b0);

    // Reset wins over an offered operand
    rst = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("prio_in_ready", in_ready, 1'b1);

    // Reset during busy cycle 2 drops the operation
    a = 28'hFFFFFFF; b = 28'hFFFFFFF; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t032_in_ready", in_ready, 1'b1);
    chk("t032_ov", out_valid, 1'b0);
    chk("t032_sum", sum, '0);
    chk("t032_cout", cout, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= out_valid;
    end
    chk("t032_no_ov", seen, 1'b0);
    run_op("t032b", 28'd5, 28'd3, 1'b0);
    chk("t032b_sum", sum, 28'd8);
    chk("t032b_cout", cout, 1'b0);
    consume();

`ifdef SEQ_ADDER_OVF_EN
    run_op("t034a", 28'h7FFFFFF, 28'h0000001, 1'b0);
    chk("t034a_sum", sum, 28'h8000000);
    chk("t034a_ovf", ovf, 1'b1);
    chk("t034a_cout", cout, 1'b0);
    consume();
    run_op("t034b", 28'hFFFFFFF, 28'h0000001, 1'b0);
    chk("t034b_sum", sum, 28'h0000000);
    chk("t034b_ovf", ovf, 1'b0);
    chk("t034b_cout", cout, 1'b1);
    consume();
`endif

    // Back-to-back random stream with handshakes tied high
    cyc = 0; last_acc = -1; n_acc = 0; n_res = 0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    while (n_res < 1000 && cyc < 10000) begin
      if (out_valid) begin
        exp_r = (expq.size() > 0) ? expq.pop_front() : 'x;
        chk("t033_res", {cout, sum}, exp_r);
        n_res++;
      end
      will_acc = 1'b0;
      if (in_ready && in_valid) begin
        expq.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
        if (last_acc >= 0) chk("t033_gap", cyc - last_acc, 6);
        last_acc = cyc;
        n_acc++;
        will_acc = 1'b1;
      end
      tick();
      cyc++;
      if (will_acc) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        if (n_acc >= 1000) in_valid = 1'b0;
      end
    end
    chk("t033_count", n_res, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
